// File: rtl/apb_mux_wd.sv
// APB completer-side multiplexer: one requester fanned out to NUM_SLAVES peripherals.
// Optional stall watchdog enabled by defining APB_MUX_WD_TIMEOUT_EN.
module apb_mux_wd #(
  parameter int unsigned NUM_SLAVES     = 8,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SEL_LSB        = 12,
  parameter int unsigned SEL_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 ctrl_psel,
  input  logic                                 ctrl_penable,
  input  logic                                 ctrl_pwrite,
  input  logic [ADDR_WIDTH-1:0]                ctrl_paddr,
  output logic [DATA_WIDTH-1:0]                ctrl_prdata,
  output logic                                 ctrl_pready,
  output logic                                 ctrl_pslverr,
  output logic [NUM_SLAVES-1:0]                slv_psel,
  output logic                                 slv_penable,
  input  logic [NUM_SLAVES-1:0]                slv_pready,
  input  logic [NUM_SLAVES-1:0]                slv_pslverr,
  input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] slv_prdata,
  input  logic                                 status_clr_i,
  output logic [2:0]                           err_sticky_o,
  output logic [ADDR_WIDTH-1:0]                err_addr_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DECERR
  } state_e;

  // Extra bit lets NUM_SLAVES == 2**SEL_WIDTH be represented in the compare.
  localparam logic [SEL_WIDTH:0] NUM_SLAVES_W = (SEL_WIDTH + 1)'(NUM_SLAVES);

  state_e                state_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic                  dec_q;
  logic [2:0]            sticky_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;

  logic [SEL_WIDTH-1:0]  idx;
  logic                  dec_err;
  logic                  setup;
  logic                  slave_ready;
  logic                  slave_err;
  logic [DATA_WIDTH-1:0] slave_rdata;
  logic                  timeout_hit;
  logic                  timeout_force;
  logic [2:0]            new_err;
  logic                  unused_pwrite;

  // Write direction is routed to the slaves outside this block.
  assign unused_pwrite = ctrl_pwrite;

  assign idx     = ctrl_paddr[SEL_LSB +: SEL_WIDTH];
  assign dec_err = ({1'b0, idx} >= NUM_SLAVES_W);
  assign setup   = ctrl_psel & ~ctrl_penable;

  always_comb begin
    slave_ready = 1'b0;
    slave_err   = 1'b0;
    slave_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_WIDTH'(i)) begin
        slave_ready = slv_pready[i];
        slave_err   = slv_pslverr[i];
        slave_rdata = slv_prdata[i];
      end
    end
  end

  always_comb begin
    slv_psel = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (state_q == ST_IDLE && setup && !dec_err && idx == SEL_WIDTH'(i)) begin
        slv_psel[i] = 1'b1;
      end
      if (state_q == ST_ACCESS && !dec_q && sel_q == SEL_WIDTH'(i)) begin
        slv_psel[i] = 1'b1;
      end
    end
  end

`ifdef APB_MUX_WD_TIMEOUT_EN
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_q;

  assign timeout_hit = (state_q == ST_ACCESS) & ctrl_psel & ctrl_penable & (wait_q == WAIT_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else if (state_q == ST_IDLE && setup) begin
      wait_q <= '0;
    end else if (state_q == ST_ACCESS && ctrl_psel && ctrl_penable && !slave_ready &&
                 wait_q != WAIT_MAX) begin
      wait_q <= wait_q + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  // TIMEOUT_CYCLES has no effect without the watchdog.
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
`endif

  // A slave answering on the limit cycle takes precedence over the watchdog.
  assign timeout_force = timeout_hit & ~slave_ready;

  always_comb begin
    slv_penable  = 1'b0;
    ctrl_pready  = 1'b0;
    ctrl_pslverr = 1'b0;
    ctrl_prdata  = '0;
    unique case (state_q)
      ST_ACCESS: begin
        slv_penable  = ctrl_penable;
        ctrl_pready  = slave_ready | timeout_hit;
        ctrl_pslverr = slave_err | timeout_force;
        ctrl_prdata  = timeout_force ? '0 : slave_rdata;
      end
      ST_DECERR: begin
        ctrl_pready  = 1'b1;
        ctrl_pslverr = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    new_err    = '0;
    new_err[0] = (state_q == ST_DECERR) & ctrl_psel & ctrl_penable;
    new_err[1] = (state_q == ST_ACCESS) & ctrl_psel & ctrl_penable & slave_ready & slave_err;
    new_err[2] = timeout_force;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      dec_q      <= 1'b0;
      sticky_q   <= '0;
      err_addr_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (setup) begin
            sel_q   <= idx;
            dec_q   <= dec_err;
            state_q <= dec_err ? ST_DECERR : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!ctrl_psel || (ctrl_penable && ctrl_pready)) begin
            state_q <= ST_IDLE;
          end
        end
        ST_DECERR: begin
          if (!ctrl_psel || ctrl_penable) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Clear first, then merge new errors so a coincident error survives the clear.
      sticky_q <= (status_clr_i ? 3'b000 : sticky_q) | new_err;
      if (|new_err) begin
        err_addr_q <= ctrl_paddr;
      end
    end
  end

  assign err_sticky_o = sticky_q;
  assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_apb_mux_wd.sv
// Directed self-checking bench for apb_mux_wd (8 slaves, 16-cycle watchdog when enabled).
module tb_apb_mux_wd;

  localparam int unsigned NS = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic                       clk_i;
  logic                       rst_ni;
  logic                       ctrl_psel;
  logic                       ctrl_penable;
  logic                       ctrl_pwrite;
  logic [AW-1:0]              ctrl_paddr;
  logic [DW-1:0]              ctrl_prdata;
  logic                       ctrl_pready;
  logic                       ctrl_pslverr;
  logic [NS-1:0]              slv_psel;
  logic                       slv_penable;
  logic [NS-1:0]              slv_pready;
  logic [NS-1:0]              slv_pslverr;
  logic [NS-1:0][DW-1:0]      slv_prdata;
  logic                       status_clr_i;
  logic [2:0]                 err_sticky_o;
  logic [AW-1:0]              err_addr_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  apb_mux_wd #(
    .NUM_SLAVES    (NS),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .SEL_LSB       (12),
    .SEL_WIDTH     (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ctrl_psel   (ctrl_psel),
    .ctrl_penable(ctrl_penable),
    .ctrl_pwrite (ctrl_pwrite),
    .ctrl_paddr  (ctrl_paddr),
    .ctrl_prdata (ctrl_prdata),
    .ctrl_pready (ctrl_pready),
    .ctrl_pslverr(ctrl_pslverr),
    .slv_psel    (slv_psel),
    .slv_penable (slv_penable),
    .slv_pready  (slv_pready),
    .slv_pslverr (slv_pslverr),
    .slv_prdata  (slv_prdata),
    .status_clr_i(status_clr_i),
    .err_sticky_o(err_sticky_o),
    .err_addr_o  (err_addr_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_ni       = 1'b0;
    ctrl_psel    = 1'b0;
    ctrl_penable = 1'b0;
    ctrl_pwrite  = 1'b0;
    ctrl_paddr   = '0;
    status_clr_i = 1'b0;
    slv_pready   = '1;
    slv_pslverr  = '0;
    for (int i = 0; i < NS; i++) slv_prdata[i] = 32'h0000_1000 * i;
    slv_prdata[3] = 32'hDEAD_BEEF;
    slv_prdata[4] = 32'h4444_0004;

    // Reset state
    mid();
    check_eq("rst_psel",   64'(slv_psel), 64'h0);
    check_eq("rst_pen",    64'(slv_penable), 64'h0);
    check_eq("rst_pready", 64'(ctrl_pready), 64'h0);
    check_eq("rst_prdata", 64'(ctrl_prdata), 64'h0);
    check_eq("rst_sticky", 64'(err_sticky_o), 64'h0);
    check_eq("rst_eaddr",  64'(err_addr_o), 64'h0);
    rst_ni = 1'b1;

    // Zero-wait read from slave 3, then back-to-back read from slave 4
    step(); ctrl_psel = 1'b1; ctrl_penable = 1'b0; ctrl_paddr = 32'h3000;
    mid();
    check_eq("s3_setup_psel",   64'(slv_psel), 64'h08);
    check_eq("s3_setup_pready", 64'(ctrl_pready), 64'h0);
    step(); ctrl_penable = 1'b1;
    mid();
    check_eq("s3_acc_psel",   64'(slv_psel), 64'h08);
    check_eq("s3_acc_pen",    64'(slv_penable), 64'h1);
    check_eq("s3_acc_pready", 64'(ctrl_pready), 64'h1);
    check_eq("s3_acc_prdata", 64'(ctrl_prdata), 64'hDEAD_BEEF);
    check_eq("s3_acc_perr",   64'(ctrl_pslverr), 64'h0);
    step(); ctrl_penable = 1'b0; ctrl_paddr = 32'h4000;
    mid();
    check_eq("b2b_setup_psel", 64'(slv_psel), 64'h10);
    check_eq("s3_sticky",      64'(err_sticky_o), 64'h0);
    step(); ctrl_penable = 1'b1;
    mid();
    check_eq("b2b_pready", 64'(ctrl_pready), 64'h1);
    check_eq("b2b_prdata", 64'(ctrl_prdata), 64'h4444_0004);
    step(); ctrl_psel = 1'b0; ctrl_penable = 1'b0;
    mid();
    check_eq("idle_psel",   64'(slv_psel), 64'h0);
    check_eq("idle_pready", 64'(ctrl_pready), 64'h0);

    // Decode error at 0xA000
    step(); ctrl_psel = 1'b1; ctrl_paddr = 32'hA000;
    mid();
    check_eq("dec_setup_psel", 64'(slv_psel), 64'h0);
    step(); ctrl_penable = 1'b1;
    mid();
    check_eq("dec_psel",   64'(slv_psel), 64'h0);
    check_eq("dec_pready", 64'(ctrl_pready), 64'h1);
    check_eq("dec_perr",   64'(ctrl_pslverr), 64'h1);
    check_eq("dec_prdata", 64'(ctrl_prdata), 64'h0);
    step(); ctrl_psel = 1'b0; ctrl_penable = 1'b0;
    mid();
    check_eq("dec_sticky", 64'(err_sticky_o), 64'h1);
    check_eq("dec_eaddr",  64'(err_addr_o), 64'hA000);
    step(); status_clr_i = 1'b1;
    mid();
    step(); status_clr_i = 1'b0;
    mid();
    check_eq("clr_sticky", 64'(err_sticky_o), 64'h0);

    // Slave 5: four wait cycles then pslverr; address moved mid-wait
    step(); ctrl_psel = 1'b1; ctrl_paddr = 32'h5000;
    slv_pready[5] = 1'b0; slv_pslverr[5] = 1'b1; slv_prdata[5] = 32'h55;
    mid();
    step(); ctrl_penable = 1'b1;
    mid();
    check_eq("s5_w1_pready", 64'(ctrl_pready), 64'h0);
    step(); ctrl_paddr = 32'h2000;
    mid();
    check_eq("s5_w2_psel", 64'(slv_psel), 64'h20);
    step();
    step();
    mid();
    check_eq("s5_w4_pready", 64'(ctrl_pready), 64'h0);
    step(); slv_pready[5] = 1'b1;
    mid();
    check_eq("s5_done_pready", 64'(ctrl_pready), 64'h1);
    check_eq("s5_done_perr",   64'(ctrl_pslverr), 64'h1);
    check_eq("s5_done_psel",   64'(slv_psel), 64'h20);
    check_eq("s5_done_prdata", 64'(ctrl_prdata), 64'h55);
    step(); ctrl_psel = 1'b0; ctrl_penable = 1'b0; slv_pslverr[5] = 1'b0;
    mid();
    check_eq("s5_sticky", 64'(err_sticky_o), 64'h2);
    check_eq("s5_eaddr",  64'(err_addr_o), 64'h2000);

    // Clear coincident with a decode-error completion: old slverr goes, decerr stays
    step(); ctrl_psel = 1'b1; ctrl_paddr = 32'hF000;
    mid();
    step(); ctrl_penable = 1'b1; status_clr_i = 1'b1;
    mid();
    step(); ctrl_psel = 1'b0; ctrl_penable = 1'b0; status_clr_i = 1'b0;
    mid();
    check_eq("clrdec_sticky", 64'(err_sticky_o), 64'h1);
    check_eq("clrdec_eaddr",  64'(err_addr_o), 64'hF000);
    step(); status_clr_i = 1'b1;
    mid();
    step(); status_clr_i = 1'b0;
    mid();
    check_eq("clr2_sticky", 64'(err_sticky_o), 64'h0);
    check_eq("clr2_eaddr",  64'(err_addr_o), 64'hF000);

`ifdef APB_MUX_WD_TIMEOUT_EN
    // Slave 2 never ready: forced completion on the 17th access cycle
    step(); ctrl_psel = 1'b1; ctrl_paddr = 32'h2000;
    slv_pready[2] = 1'b0; slv_prdata[2] = 32'h22;
    mid();
    step(); ctrl_penable = 1'b1;
    for (int k = 2; k <= 16; k++) step();
    mid();
    check_eq("to_w16_pready", 64'(ctrl_pready), 64'h0);
    step();
    mid();
    check_eq("to_pready", 64'(ctrl_pready), 64'h1);
    check_eq("to_perr",   64'(ctrl_pslverr), 64'h1);
    check_eq("to_prdata", 64'(ctrl_prdata), 64'h0);
    check_eq("to_psel",   64'(slv_psel), 64'h04);
    step(); ctrl_psel = 1'b0; ctrl_penable = 1'b0;
    mid();
    check_eq("to_after_psel", 64'(slv_psel), 64'h0);
    check_eq("to_sticky",     64'(err_sticky_o), 64'h4);
    step(); status_clr_i = 1'b1;
    mid();
    step(); status_clr_i = 1'b0;
    // Slave ready exactly at the limit cycle wins
    ctrl_psel = 1'b1; ctrl_paddr = 32'h2000;
    mid();
    step(); ctrl_penable = 1'b1;
    for (int k = 2; k <= 16; k++) step();
    step(); slv_pready[2] = 1'b1;
    mid();
    check_eq("lim_pready", 64'(ctrl_pready), 64'h1);
    check_eq("lim_perr",   64'(ctrl_pslverr), 64'h0);
    check_eq("lim_prdata", 64'(ctrl_prdata), 64'h22);
    step(); ctrl_psel = 1'b0; ctrl_penable = 1'b0;
    mid();
    check_eq("lim_sticky", 64'(err_sticky_o), 64'h0);
`else
    // Without the watchdog a long stall just keeps waiting
    step(); ctrl_psel = 1'b1; ctrl_paddr = 32'h2000;
    slv_pready[2] = 1'b0; slv_prdata[2] = 32'h22;
    mid();
    step(); ctrl_penable = 1'b1;
    for (int k = 2; k <= 20; k++) step();
    mid();
    check_eq("nowd_w20_pready", 64'(ctrl_pready), 64'h0);
    step(); slv_pready[2] = 1'b1;
    mid();
    check_eq("nowd_pready", 64'(ctrl_pready), 64'h1);
    check_eq("nowd_prdata", 64'(ctrl_prdata), 64'h22);
    step(); ctrl_psel = 1'b0; ctrl_penable = 1'b0;
    mid();
    check_eq("nowd_sticky", 64'(err_sticky_o), 64'h0);
`endif

    // Reset during slave 1 wait, then a clean transfer to slave 0
    step(); ctrl_psel = 1'b1; ctrl_paddr = 32'h1000; slv_pready[1] = 1'b0;
    mid();
    step(); ctrl_penable = 1'b1;
    mid();
    check_eq("s1_psel", 64'(slv_psel), 64'h02);
    step();
    #1 rst_ni = 1'b0;
    #1;
    check_eq("mrst_psel",   64'(slv_psel), 64'h0);
    check_eq("mrst_pen",    64'(slv_penable), 64'h0);
    check_eq("mrst_pready", 64'(ctrl_pready), 64'h0);
    check_eq("mrst_eaddr",  64'(err_addr_o), 64'h0);
    mid();
    rst_ni = 1'b1; ctrl_psel = 1'b0; ctrl_penable = 1'b0;
    step(); ctrl_psel = 1'b1; ctrl_paddr = 32'h0000;
    slv_pready[0] = 1'b1; slv_prdata[0] = 32'h1234_5678;
    mid();
    check_eq("s0_setup_psel", 64'(slv_psel), 64'h01);
    step(); ctrl_penable = 1'b1;
    mid();
    check_eq("s0_pready", 64'(ctrl_pready), 64'h1);
    check_eq("s0_prdata", 64'(ctrl_prdata), 64'h1234_5678);
    check_eq("s0_perr",   64'(ctrl_pslverr), 64'h0);
    step(); ctrl_psel = 1'b0; ctrl_penable = 1'b0;
    mid();
    check_eq("s0_sticky", 64'(err_sticky_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_mux_wd.md
# apb_mux_wd

Parametrised APB completer-side multiplexer: routes one APB requester (the axi2apb bridge control port) to NUM_SLAVES peripherals. Slave index comes from a configurable paddr bit field. Out-of-range indices get a decode-error response. Each transfer is registered: the slave index is latched and tracked through a setup/access state machine. An optional watchdog aborts stalled accesses, and sticky error status with a captured error address is kept for software.

## Interface
- NUM_SLAVES, 8: number of slave ports, 1..2**SEL_WIDTH
- ADDR_WIDTH, 32: paddr width
- DATA_WIDTH, 32: prdata/pwdata width
- SEL_LSB, 12: lowest paddr bit of the slave-select field
- SEL_WIDTH, 4: width of the slave-select field
- TIMEOUT_CYCLES, 256: watchdog limit in wait cycles, >= 1 (used only with APB_MUX_WD_TIMEOUT_EN)
- clk_i  in  1  clock; all logic is on the rising edge
- rst_ni  in  1  asynchronous active-low reset
- ctrl_psel, ctrl_penable, ctrl_pwrite  in  1  requester APB control
- ctrl_paddr  in  ADDR_WIDTH  requester address
- ctrl_prdata  out  DATA_WIDTH  read data returned to the requester
- ctrl_pready, ctrl_pslverr  out  1  requester response
- slv_psel  out  NUM_SLAVES  one-hot slave select
- slv_penable  out  1  enable, broadcast to all slaves
- slv_pready, slv_pslverr  in  NUM_SLAVES  per-slave response
- slv_prdata  in  NUM_SLAVES x DATA_WIDTH  per-slave read data
- status_clr_i  in  1  clears sticky status on a single-cycle pulse
- err_sticky_o  out  3  sticky error flags: {timeout, slverr, decerr}
- err_addr_o  out  ADDR_WIDTH  ctrl_paddr of the most recent errored transfer

## Operation
- idx = ctrl_paddr[SEL_LSB +: SEL_WIDTH]. dec_err = (idx >= NUM_SLAVES).
- FSM has three states: IDLE, ACCESS, DECERR.
  - IDLE, ctrl_psel=1, ctrl_penable=0 (setup phase): latch idx into sel_q and dec_err into dec_q, clear the wait counter. Go to DECERR if dec_err is set, otherwise go to ACCESS.
  - ACCESS: slv_psel[sel_q]=1 and slv_penable=ctrl_penable. Response outputs mirror slave sel_q. On ctrl_penable & ctrl_pready, return to IDLE.
  - DECERR: no slave is selected. ctrl_pready=1, ctrl_pslverr=1, ctrl_prdata=0. Return to IDLE when ctrl_penable=1.
- During the setup cycle in IDLE, slv_psel[idx] = ctrl_psel & ~dec_err (combinational), so slaves see a correct APB setup phase.
- In IDLE, ctrl_pready=0, ctrl_pslverr=0, ctrl_prdata=0.
- Address changes after setup are ignored because sel_q is held for the whole access.
- ctrl_psel dropping while in ACCESS or DECERR is a protocol violation. The FSM returns to IDLE and nothing is recorded.
- Sticky flags are set on any completing cycle that carries an error:
  - decerr: completion in DECERR
  - slverr: slave completion with pslverr=1
  - timeout: watchdog completion
- On every error completion, err_addr_o captures ctrl_paddr.
- If status_clr_i and a new error occur in the same cycle, the new error wins: its flag stays set and its address is captured.

## Timing
- Reset values: FSM in IDLE, sel_q=0, dec_q=0, wait counter 0, err_sticky_o=0, err_addr_o=0, slv_psel=0, slv_penable=0, ctrl_pready=0, ctrl_pslverr=0, ctrl_prdata=0.
- Reset asserted mid-transfer returns everything to the values above immediately. No response is issued.
- The block adds no latency: a zero-wait slave completes in the cycle after setup, exactly as with no mux.
- A decode error completes in the first access cycle.
- Back-to-back transfers work: a setup phase arriving in the cycle after completion is accepted from IDLE.
- Status outputs update on the clock edge after the completing cycle.

## Configuration
- APB_MUX_WD_TIMEOUT_EN defined: the wait counter increments on each ACCESS cycle with ctrl_penable=1 and slave pready=0, saturating at TIMEOUT_CYCLES.
  - The watchdog completes the transfer on the cycle where count == TIMEOUT_CYCLES: it forces ctrl_pready=1, ctrl_pslverr=1, ctrl_prdata=0 and sets the timeout flag.
  - The slave stays selected through that cycle and is deselected in IDLE after it. Its late response is ignored.
  - If the slave's pready arrives in the same cycle the limit is reached, the slave response wins and the timeout flag is not set.
- APB_MUX_WD_TIMEOUT_EN undefined: no counter is built, transfers wait indefinitely, and err_sticky_o[2] is tied to 0.

## Test plan
- Read from idx 3 (paddr 0x3000), slave 3 with zero wait returning 0xDEADBEEF -> only slv_psel[3] asserted; ctrl_prdata=0xDEADBEEF with ctrl_pready=1 on the first access cycle; err_sticky_o=0.
- Access to paddr 0xA000 with NUM_SLAVES=8 -> no slv_psel bit asserted; ctrl_pready=1, ctrl_pslverr=1, ctrl_prdata=0; err_sticky_o=3'b001, err_addr_o=0xA000.
- Slave 5 holds pready low for 4 cycles, then responds with pslverr=1 -> completion on the 5th access cycle; err_sticky_o[1]=1; ctrl_paddr changed during the wait does not move slv_psel off bit 5.
- With the macro defined and TIMEOUT_CYCLES=16, slave 2 never ready -> forced completion with pslverr=1 after 16 wait cycles; slv_psel[2] drops the next cycle; err_sticky_o[2]=1. Repeat with slave pready arriving exactly at cycle 16 -> normal completion, no timeout flag.
- Pulse status_clr_i in the same cycle as a decode-error completion -> err_sticky_o=3'b001 afterwards; a second clear pulse with no error -> 0.
- Assert rst_ni low during the ACCESS wait of slave 1 -> all outputs 0 immediately; the next transfer to slave 0 completes normally.
